// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge: LED/display registers, debounced switches with a
// sticky change flag, and a multiplexed 4-digit seven-segment scanner.
module io_bridge #(
    parameter int N          = 64,
    parameter int DEB_CYCLES = 16,
    parameter int SCAN_DIV   = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    input  logic         DM_readEnable,
    input  logic [N-1:0] mem_readData,
    output logic         mem_writeEnable,
    output logic [N-1:0] readData,
    input  logic [15:0]  i_sw,
    output logic [15:0]  o_led,
    output logic [6:0]   seg,
    output logic [3:0]   dig_en
);

    localparam logic [N-1:0] ADDR_LED  = N'(64'h8000);
    localparam logic [N-1:0] ADDR_SW   = N'(64'h8008);
    localparam logic [N-1:0] ADDR_DISP = N'(64'h8010);
    localparam logic [N-1:0] ADDR_STAT = N'(64'h8018);
    localparam logic [7:0]   DEB_MAX   = 8'(DEB_CYCLES);
    localparam logic [15:0]  SCAN_LAST = 16'(SCAN_DIV - 1);

    // Segment pattern {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    logic [15:0] o_led_q, o_led_d;
    logic [19:0] disp_q, disp_d;
    logic [15:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [15:0] sw_prev_q, sw_prev_d, sw_stable_q, sw_stable_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        changed_q, changed_d;
    logic [15:0] presc_q, presc_d;
    logic [1:0]  idx_q, idx_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  dig_en_q, dig_en_d;

    logic hit_led_s, hit_sw_s, hit_disp_s, hit_stat_s, io_hit_s;
    logic set_s, clr_s;
    logic [3:0] nib_s, blank_s;
    logic unused_s;

    assign unused_s = ^DM_writeData[N-1:20];
    assign o_led    = o_led_q;
    assign seg      = seg_q;
    assign dig_en   = dig_en_q;

    // Address decode, memory strobe gating and load-data mux.
    always_comb begin
        hit_led_s       = (DM_addr == ADDR_LED);
        hit_sw_s        = (DM_addr == ADDR_SW);
        hit_disp_s      = (DM_addr == ADDR_DISP);
        hit_stat_s      = (DM_addr == ADDR_STAT);
        io_hit_s        = hit_led_s | hit_sw_s | hit_disp_s | hit_stat_s;
        mem_writeEnable = DM_writeEnable & ~io_hit_s;
        if (hit_led_s) begin
            readData = {{(N-16){1'b0}}, o_led_q};
        end else if (hit_sw_s) begin
            readData = {{(N-16){1'b0}}, sw_stable_q};
        end else if (hit_disp_s) begin
            readData = {{(N-20){1'b0}}, disp_q};
        end else if (hit_stat_s) begin
            readData = {{(N-1){1'b0}}, changed_q};
        end else begin
            readData = mem_readData;
        end
    end

    // Register writes, switch synchronizer/debounce and the change flag.
    always_comb begin
        o_led_d     = o_led_q;
        disp_d      = disp_q;
        sync1_d     = i_sw;
        sync2_d     = sync1_q;
        sw_prev_d   = sync2_q;
        cnt_d       = cnt_q;
        sw_stable_d = sw_stable_q;
        set_s       = 1'b0;
        clr_s       = DM_readEnable & hit_stat_s;
        if (DM_writeEnable && hit_led_s) begin
            o_led_d = DM_writeData[15:0];
        end else begin
            o_led_d = o_led_q;
        end
        if (DM_writeEnable && hit_disp_s) begin
            disp_d = DM_writeData[19:0];
        end else begin
            disp_d = disp_q;
        end
        // A stable load needs the input unchanged this cycle too, so a fresh
        // edge arriving while the counter is saturated never slips through.
        if (sync2_q != sw_prev_q) begin
            cnt_d = 8'd0;
        end else begin
            if (cnt_q != DEB_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end
            if ((cnt_q == DEB_MAX) && (sync2_q != sw_stable_q)) begin
                sw_stable_d = sync2_q;
                set_s       = 1'b1;
            end else begin
                sw_stable_d = sw_stable_q;
            end
        end
        if (set_s) begin
            changed_d = 1'b1;
        end else if (clr_s) begin
            changed_d = 1'b0;
        end else begin
            changed_d = changed_q;
        end
    end

    // Display scan; outputs decode the next index so they stay aligned with it.
    always_comb begin
        presc_d  = presc_q;
        idx_d    = idx_q;
        nib_s    = 4'h0;
        blank_s  = disp_d[19:16];
        seg_d    = seg_q;
        dig_en_d = dig_en_q;
        if (presc_q == SCAN_LAST) begin
            presc_d = 16'd0;
            idx_d   = idx_q + 2'd1;
        end else begin
            presc_d = presc_q + 16'd1;
            idx_d   = idx_q;
        end
        case (idx_d)
            2'd0:    nib_s = disp_d[3:0];
            2'd1:    nib_s = disp_d[7:4];
            2'd2:    nib_s = disp_d[11:8];
            2'd3:    nib_s = disp_d[15:12];
            default: nib_s = disp_d[3:0];
        endcase
        seg_d = hex_to_seg(nib_s);
        if (blank_s[idx_d]) begin
            dig_en_d = 4'b1111;
        end else begin
            dig_en_d = ~(4'b0001 << idx_d);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_led_q     <= 16'h0000;
            disp_q      <= 20'h00000;
            sync1_q     <= 16'h0000;
            sync2_q     <= 16'h0000;
            sw_prev_q   <= 16'h0000;
            sw_stable_q <= 16'h0000;
            cnt_q       <= 8'd0;
            changed_q   <= 1'b0;
            presc_q     <= 16'd0;
            idx_q       <= 2'd0;
            seg_q       <= 7'b1000000;
            dig_en_q    <= 4'b1110;
        end else begin
            o_led_q     <= o_led_d;
            disp_q      <= disp_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sw_prev_q   <= sw_prev_d;
            sw_stable_q <= sw_stable_d;
            cnt_q       <= cnt_d;
            changed_q   <= changed_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            dig_en_q    <= dig_en_d;
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: bus decode, LED/DISP registers, switch
// debounce with clear-on-read status, and the digit scanner.
module tb_io_bridge;

    localparam int N    = 64;
    localparam int DEB  = 16;
    localparam int SDIV = 4;

    localparam logic [63:0] A_LED  = 64'h8000;
    localparam logic [63:0] A_SW   = 64'h8008;
    localparam logic [63:0] A_DISP = 64'h8010;
    localparam logic [63:0] A_STAT = 64'h8018;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] DM_addr, DM_writeData, mem_readData, readData;
    logic         DM_writeEnable, DM_readEnable, mem_writeEnable;
    logic [15:0]  i_sw, o_led;
    logic [6:0]   seg;
    logic [3:0]   dig_en;

    int total = 0;
    int bad   = 0;

    io_bridge #(.N(N), .DEB_CYCLES(DEB), .SCAN_DIV(SDIV)) dut (
        .clk(clk), .reset(reset),
        .DM_addr(DM_addr), .DM_writeData(DM_writeData),
        .DM_writeEnable(DM_writeEnable), .DM_readEnable(DM_readEnable),
        .mem_readData(mem_readData), .mem_writeEnable(mem_writeEnable),
        .readData(readData), .i_sw(i_sw), .o_led(o_led),
        .seg(seg), .dig_en(dig_en)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_bus(input logic [63:0] a, input logic [63:0] d,
                           input logic we, input logic re);
        DM_addr        = a;
        DM_writeData   = d;
        DM_writeEnable = we;
        DM_readEnable  = re;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        i_sw = 16'h0000;
        mem_readData = 64'h0;
        set_bus(64'h0, 64'h0, 1'b0, 1'b0);
        #2;
        total++; if (o_led !== 16'h0000) begin bad++; $display("FAIL rst_led got=%h want=0000", o_led); end
        total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL rst_seg got=%b want=1000000", seg); end
        total++; if (dig_en !== 4'b1110) begin bad++; $display("FAIL rst_dig got=%b want=1110", dig_en); end
        set_bus(A_SW, 64'h0, 1'b0, 1'b0);
        total++; if (readData !== 64'h0) begin bad++; $display("FAIL rst_sw got=%h want=0", readData); end
        set_bus(A_STAT, 64'h0, 1'b0, 1'b0);
        total++; if (readData !== 64'h0) begin bad++; $display("FAIL rst_stat got=%h want=0", readData); end
        @(negedge clk);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_led;
        set_bus(A_LED, 64'hFFFF_0000_0000_A5A5, 1'b1, 1'b0);
        total++; if (mem_writeEnable !== 1'b0) begin bad++; $display("FAIL led_memwe got=%b want=0", mem_writeEnable); end
        total++; if (o_led !== 16'h0000) begin bad++; $display("FAIL led_early got=%h want=0000", o_led); end
        tick(1);
        set_bus(A_LED, 64'h1234, 1'b0, 1'b1);
        total++; if (o_led !== 16'hA5A5) begin bad++; $display("FAIL led_val got=%h want=a5a5", o_led); end
        total++; if (readData !== 64'hA5A5) begin bad++; $display("FAIL led_rd got=%h want=a5a5", readData); end
        tick(1);
        total++; if (o_led !== 16'hA5A5) begin bad++; $display("FAIL led_nowe got=%h want=a5a5", o_led); end
    endtask

    task automatic test_mem;
        mem_readData = 64'hDEAD_BEEF_0123_4567;
        set_bus(64'h0010, 64'h55, 1'b1, 1'b0);
        total++; if (mem_writeEnable !== 1'b1) begin bad++; $display("FAIL mem_we got=%b want=1", mem_writeEnable); end
        total++; if (readData !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL mem_rd got=%h want=deadbeef01234567", readData); end
        set_bus(64'h0010, 64'h55, 1'b0, 1'b1);
        total++; if (mem_writeEnable !== 1'b0) begin bad++; $display("FAIL mem_we0 got=%b want=0", mem_writeEnable); end
        set_bus(64'h1_0000_8000, 64'h55, 1'b1, 1'b1);
        total++; if (mem_writeEnable !== 1'b1) begin bad++; $display("FAIL alias_we got=%b want=1", mem_writeEnable); end
        total++; if (readData !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL alias_rd got=%h want=deadbeef01234567", readData); end
        set_bus(64'h8004, 64'h55, 1'b1, 1'b0);
        total++; if (mem_writeEnable !== 1'b1) begin bad++; $display("FAIL odd_we got=%b want=1", mem_writeEnable); end
        set_bus(A_STAT, 64'hFFFF, 1'b1, 1'b0);
        total++; if (mem_writeEnable !== 1'b0) begin bad++; $display("FAIL stat_we got=%b want=0", mem_writeEnable); end
        set_bus(A_SW, 64'hFFFF, 1'b1, 1'b0);
        total++; if (mem_writeEnable !== 1'b0) begin bad++; $display("FAIL sw_we got=%b want=0", mem_writeEnable); end
        tick(1);
        set_bus(A_SW, 64'h0, 1'b0, 1'b0);
        total++; if (readData !== 64'h0) begin bad++; $display("FAIL sw_ro got=%h want=0", readData); end
    endtask

    task automatic test_debounce;
        // First sampling edge is the next one; the value lands DEB+3 edges after it.
        i_sw = 16'h0001;
        tick(DEB + 3);
        total++; if (readData !== 64'h0) begin bad++; $display("FAIL deb_early got=%h want=0", readData); end
        tick(1);
        total++; if (readData !== 64'h1) begin bad++; $display("FAIL deb_val got=%h want=1", readData); end
        set_bus(A_STAT, 64'h0, 1'b0, 1'b0);
        total++; if (readData !== 64'h1) begin bad++; $display("FAIL stat_set got=%h want=1", readData); end
        set_bus(A_STAT, 64'h0, 1'b0, 1'b1);
        total++; if (readData !== 64'h1) begin bad++; $display("FAIL stat_rd1 got=%h want=1", readData); end
        tick(1);
        total++; if (readData !== 64'h0) begin bad++; $display("FAIL stat_rd2 got=%h want=0", readData); end
        set_bus(A_SW, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic test_bounce;
        for (int k = 0; k < 10; k++) begin
            i_sw = (k % 2 == 0) ? 16'h0003 : 16'h0001;
            tick(4);
            total++; if (readData !== 64'h1) begin bad++; $display("FAIL bounce_sw k=%0d got=%h want=1", k, readData); end
        end
        tick(DEB + 10);
        total++; if (readData !== 64'h1) begin bad++; $display("FAIL bounce_end got=%h want=1", readData); end
        set_bus(A_STAT, 64'h0, 1'b0, 1'b0);
        total++; if (readData !== 64'h0) begin bad++; $display("FAIL bounce_stat got=%h want=0", readData); end
        set_bus(A_SW, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic test_stat_race;
        i_sw = 16'h0000;
        tick(DEB + 3);
        total++; if (readData !== 64'h1) begin bad++; $display("FAIL race_pre got=%h want=1", readData); end
        set_bus(A_STAT, 64'h0, 1'b0, 1'b1);
        tick(1);
        set_bus(A_STAT, 64'h0, 1'b0, 1'b0);
        total++; if (readData !== 64'h1) begin bad++; $display("FAIL race_stat got=%h want=1", readData); end
        set_bus(A_SW, 64'h0, 1'b0, 1'b0);
        total++; if (readData !== 64'h0) begin bad++; $display("FAIL race_sw got=%h want=0", readData); end
    endtask

    task automatic test_scan;
        reset = 1'b1;
        #1;
        total++; if (o_led !== 16'h0000) begin bad++; $display("FAIL mid_led got=%h want=0000", o_led); end
        total++; if (dig_en !== 4'b1110) begin bad++; $display("FAIL mid_dig got=%b want=1110", dig_en); end
        set_bus(A_STAT, 64'h0, 1'b0, 1'b0);
        total++; if (readData !== 64'h0) begin bad++; $display("FAIL mid_stat got=%h want=0", readData); end
        set_bus(A_DISP, 64'h2_1234, 1'b1, 1'b0);
        reset = 1'b0;
        tick(1);
        set_bus(A_DISP, 64'h0, 1'b0, 1'b1);
        total++; if (readData !== 64'h2_1234) begin bad++; $display("FAIL disp_rd got=%h want=21234", readData); end
        total++; if (dig_en !== 4'b1110 || seg !== 7'b0011001) begin bad++; $display("FAIL scan_d0 got=%b/%b want=1110/0011001", dig_en, seg); end
        tick(SDIV - 2);
        total++; if (dig_en !== 4'b1110) begin bad++; $display("FAIL scan_hold got=%b want=1110", dig_en); end
        tick(1);
        total++; if (dig_en !== 4'b1111 || seg !== 7'b0110000) begin bad++; $display("FAIL scan_d1 got=%b/%b want=1111/0110000", dig_en, seg); end
        tick(SDIV);
        total++; if (dig_en !== 4'b1011 || seg !== 7'b0100100) begin bad++; $display("FAIL scan_d2 got=%b/%b want=1011/0100100", dig_en, seg); end
        tick(SDIV);
        total++; if (dig_en !== 4'b0111 || seg !== 7'b1111001) begin bad++; $display("FAIL scan_d3 got=%b/%b want=0111/1111001", dig_en, seg); end
        set_bus(A_DISP, 64'h0_F8A0, 1'b1, 1'b0);
        tick(SDIV);
        set_bus(A_STAT, 64'h0, 1'b0, 1'b0);
        total++; if (dig_en !== 4'b1110 || seg !== 7'b1000000) begin bad++; $display("FAIL hex_0 got=%b/%b want=1110/1000000", dig_en, seg); end
        tick(SDIV);
        total++; if (dig_en !== 4'b1101 || seg !== 7'b0001000) begin bad++; $display("FAIL hex_a got=%b/%b want=1101/0001000", dig_en, seg); end
        tick(SDIV);
        total++; if (dig_en !== 4'b1011 || seg !== 7'b0000000) begin bad++; $display("FAIL hex_8 got=%b/%b want=1011/0000000", dig_en, seg); end
        tick(SDIV);
        total++; if (dig_en !== 4'b0111 || seg !== 7'b0001110) begin bad++; $display("FAIL hex_f got=%b/%b want=0111/0001110", dig_en, seg); end
        total++; if (readData !== 64'h0) begin bad++; $display("FAIL post_stat got=%h want=0", readData); end
    endtask

    initial begin
        test_reset();
        test_led();
        test_mem();
        test_debounce();
        test_bounce();
        test_stat_race();
        test_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
